reg_file16: RTL

Sixteen-entry, 16-bit register file with two read ports and one write port for the 16-bit multi-cycle datapath. Read data is captured in output registers `a_out` and `b_out`, which act as the A/B operand latches. `b_out` drives `in0` of the ALU-source 2:1 mux, whose `in1` carries the immediate. Register 0 always reads zero. The stack-pointer register has a non-zero reset value.

---
 rtl/reg_file16_if.sv | 36 +++
 rtl/reg_file16.sv | 75 +++++++
 2 files changed

// File: rtl/reg_file16_if.sv
// ---------------------------------------------------------------------------
// reg_file16_if
//   Bus bundle for the 16-entry register file: two read ports, one write port
//   and the two registered operand outputs.
//
//   master : the side driving addresses, enables and write data (sequencer / bench)
//   slave  : the register file itself
//
//   rd_addr_a / rd_addr_b  4-bit read addresses, ports A and B
//   rd_en                  load strobe for a_out / b_out
//   wr_addr / wr_data      write address and data
//   wr_en                  write strobe
//   a_out / b_out          registered read data (A/B operand latches)
// ---------------------------------------------------------------------------
interface reg_file16_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       rd_addr_a;
    logic [3:0]       rd_addr_b;
    logic             rd_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;

    modport master (
        output rd_addr_a, rd_addr_b, rd_en, wr_addr, wr_data, wr_en,
        input  a_out, b_out
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, rd_en, wr_addr, wr_data, wr_en,
        output a_out, b_out
    );
endinterface

// File: rtl/reg_file16.sv
// ---------------------------------------------------------------------------
// reg_file16
//   Sixteen-entry register file, two read ports, one write port. Register 0
//   has no storage and always reads zero; the stack-pointer register resets to
//   SP_INIT. Read data is captured in a_out / b_out (the A/B operand latches),
//   which load only when rd_en is high. A read of the register being written
//   in the same cycle returns the new write data (write-first bypass).
//
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    reg_file16_if.slave (addresses, enables, write data, a_out/b_out)
// ---------------------------------------------------------------------------
module reg_file16 #(
    parameter int               WIDTH    = 16,
    parameter int               SP_INDEX = 15,
    parameter logic [WIDTH-1:0] SP_INIT  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    reg_file16_if.slave bus
);
    localparam int DEPTH = 16;

    // Storage exists only for registers 1..15.
    logic [WIDTH-1:0] regs_q  [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d  [1:DEPTH-1];

    // Read view of every address including the write-first bypass;
    // entry 0 is the hard-wired zero register.
    logic [WIDTH-1:0] rd_view [0:DEPTH-1];

    logic [WIDTH-1:0] a_out_q, a_out_d;
    logic [WIDTH-1:0] b_out_q, b_out_d;

    assign rd_view[0] = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
            logic hit;
            assign hit         = bus.wr_en && (bus.wr_addr == 4'(gi));
            assign regs_d[gi]  = hit ? bus.wr_data : regs_q[gi];
            // A same-cycle write to this entry is visible to both read ports.
            assign rd_view[gi] = hit ? bus.wr_data : regs_q[gi];
        end
    endgenerate

    always_comb begin
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        if (bus.rd_en) begin
            a_out_d = rd_view[bus.rd_addr_a];
            b_out_d = rd_view[bus.rd_addr_b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign bus.a_out = a_out_q;
    assign bus.b_out = b_out_q;

endmodule
